// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//
// Purpose:
//   Walks the select lines of an 8-to-1 channel multiplexer through the set
//   of channels enabled in a mask. It holds each select code for DWELL
//   cycles, then captures the multiplexer output and offers it on a
//   valid/ready stream tagged with the channel code. Channels are visited in
//   ascending order. Disabled channels cost no cycles.
//
// Parameters:
//   DWELL   cycles each select code is held before f is sampled (1..15)
//   DATA_W  width of the multiplexer data path
//
// Ports:
//   clk        in   single clock, rising-edge active
//   rst        in   synchronous active-high reset
//   start      in   request one scan, accepted only while idle
//   mask       in   channel enable (bit n = code n), latched on acceptance
//   s2,s1,s0   out  registered select code to the multiplexer
//   f          in   multiplexer output for the current select code
//   busy       out  high from start acceptance until the done cycle
//   out_valid  out  capture available
//   out_ready  in   downstream accepts capture
//   out_ch     out  select code the capture was taken on
//   out_data   out  captured value of f
//   done       out  one-cycle pulse at scan end
//
// Optional feature (macro SCAN_CHANGE_DETECT_EN):
//   Keeps a per-channel shadow of the last accepted value. A channel whose
//   sampled value equals its shadow produces no capture, and the scan moves
//   on immediately at the sampling edge.
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int DWELL  = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        mask,
    output logic              s2,
    output logic              s1,
    output logic              s0,
    input  logic [DATA_W-1:0] f,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        FINISH
    } state_t;

    state_t              state_q;
    logic [7:0]          mask_q;
    logic [2:0]          sel_q;
    logic [3:0]          dwellCnt_q;
    logic                busy_q;
    logic                outValid_q;
    logic [2:0]          outCh_q;
    logic [DATA_W-1:0]   outData_q;
    logic                done_q;

    logic [2:0]          firstCode_d;
    logic [2:0]          nextCode_d;
    logic                nextValid_d;
    logic                skip_d;

    // Lowest enabled code of the incoming mask, used on start acceptance
    // before the mask has been latched.
    always_comb begin
        firstCode_d = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                firstCode_d = 3'(i);
            end
        end
    end

    // Lowest enabled code strictly above the current select code, taken
    // from the latched mask so mask changes mid-scan have no effect.
    always_comb begin
        nextCode_d  = sel_q;
        nextValid_d = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                nextCode_d  = 3'(i);
                nextValid_d = 1'b1;
            end
        end
    end

`ifdef SCAN_CHANGE_DETECT_EN
    logic [DATA_W-1:0] shadow_q [8];
    logic [7:0]        seen_q;

    // An unchanged value on a channel seen before is dropped at sampling.
    assign skip_d = seen_q[sel_q] && (f == shadow_q[sel_q]);
`else
    assign skip_d = 1'b0;
`endif

    // Scan FSM. All outputs are registers updated here. A handshake in HOLD
    // and a skipped sample in SETTLE advance the scan in the same way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= 8'd0;
            sel_q      <= 3'd0;
            dwellCnt_q <= 4'd0;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
            outCh_q    <= 3'd0;
            outData_q  <= '0;
            done_q     <= 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
            seen_q     <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mask_q     <= mask;
                        dwellCnt_q <= 4'd0;
                        if (mask == 8'd0) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            sel_q   <= firstCode_d;
                            busy_q  <= 1'b1;
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (dwellCnt_q == 4'(DWELL - 1)) begin
                        dwellCnt_q <= 4'd0;
                        if (skip_d) begin
                            if (nextValid_d) begin
                                sel_q <= nextCode_d;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= FINISH;
                            end
                        end else begin
                            outValid_q <= 1'b1;
                            outData_q  <= f;
                            outCh_q    <= sel_q;
                            state_q    <= HOLD;
                        end
                    end else begin
                        dwellCnt_q <= dwellCnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
                        shadow_q[outCh_q] <= outData_q;
                        seen_q[outCh_q]   <= 1'b1;
`endif
                        if (nextValid_d) begin
                            sel_q   <= nextCode_d;
                            state_q <= SETTLE;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {s2, s1, s0} = sel_q;
    assign busy         = busy_q;
    assign out_valid    = outValid_q;
    assign out_ch       = outCh_q;
    assign out_data     = outData_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Self-checking bench for mux_scan_sequencer with DWELL=2, DATA_W=4. The
// multiplexer is modelled as f = select code + base (plus an optional bump
// on channel 4). A table of full scans with hand-computed captures is
// applied in a loop, followed by hand-written sequences for back-pressure,
// ignored restarts and mid-HOLD reset.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    localparam int DWELL  = 2;
    localparam int DATA_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        mask;
    logic              s2;
    logic              s1;
    logic              s0;
    logic [DATA_W-1:0] f;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_ch;
    logic [DATA_W-1:0] out_data;
    logic              done;

    logic [3:0]        base;
    logic              bumpCh4;
    logic [2:0]        sel;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;

    logic              monActive = 1'b0;
    logic [7:0]        curMask;
    logic [6:0]        capQ [$];
    int                capCyc [$];
    int                doneCount;
    int                doneCycle;
    int                doneWithBusy;
    logic              busySeen;
    int                badSel;
    int                c0;

    typedef struct packed {
        logic [7:0]  mask;
        logic [3:0]  base;
        logic [3:0]  expCount;
        logic [23:0] expChs;
        logic [31:0] expData;
        logic [7:0]  expLat;
        logic        expBusy;
    } scanVec_t;

    scanVec_t vecs [4];

    mux_scan_sequencer #(
        .DWELL (DWELL),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mask     (mask),
        .s2       (s2),
        .s1       (s1),
        .s0       (s0),
        .f        (f),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_data (out_data),
        .done     (done)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Combinational multiplexer model driven by the select lines.
    assign sel = {s2, s1, s0};
    always_comb begin
        f = 4'(sel) + base + ((bumpCh4 && (sel == 3'd4)) ? 4'd1 : 4'd0);
    end

    // Scan monitor, sampling on the falling edge: logs handshakes that the
    // next rising edge will complete, done pulses, busy and select codes.
    always @(negedge clk) begin
        if (monActive) begin
            if (out_valid && out_ready && !rst) begin
                capQ.push_back({out_ch, out_data});
                capCyc.push_back(cycle);
            end
            if (done) begin
                if (doneCount == 0) doneCycle = cycle;
                doneCount++;
                if (busy) doneWithBusy++;
            end
            if (busy) busySeen = 1'b1;
            if ((curMask != 8'd0) && !curMask[sel]) badSel++;
        end
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Launch one scan: the rising edge after raising start is acceptance
    // edge E0. The mask input is scrambled afterwards to show it is ignored.
    task automatic applyStimulus(input logic [7:0] m, input logic [3:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        mask  = m;
        base  = b;
        capQ.delete();
        capCyc.delete();
        doneCount    = 0;
        doneCycle    = 0;
        doneWithBusy = 0;
        busySeen     = 1'b0;
        badSel       = 0;
        curMask      = m;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mask      = ~m;
        c0        = cycle;
        monActive = 1'b1;
    endtask

    // Wait (bounded) for done, then let it drop and the FSM return to idle.
    task automatic waitScanDone(output int lat);
        for (int i = 0; i < 300 && doneCount == 0; i++) @(negedge clk);
        checks++;
        if (doneCount == 0) begin
            fails++;
            $display("[TB] FAIL doneTimeout: got no done, expected done within 300 cycles");
        end
        repeat (2) @(negedge clk);
        monActive = 1'b0;
        lat = doneCycle - c0;
    endtask

    initial begin
        int lat;
        int hb;
        logic [2:0] eCh;
        logic [3:0] eData;

        rst       = 1'b1;
        start     = 1'b0;
        mask      = 8'd0;
        out_ready = 1'b1;
        base      = 4'd0;
        bumpCh4   = 1'b0;

        vecs[0] = '{mask: 8'hFF, base: 4'd3, expCount: 4'd8,
                    expChs:  {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                    expData: {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3},
                    expLat: 8'd24, expBusy: 1'b1};
        vecs[1] = '{mask: 8'hA4, base: 4'd5, expCount: 4'd3,
                    expChs:  {15'd0, 3'd7, 3'd5, 3'd2},
                    expData: {20'd0, 4'd12, 4'd10, 4'd7},
                    expLat: 8'd9, expBusy: 1'b1};
        vecs[2] = '{mask: 8'h81, base: 4'd1, expCount: 4'd2,
                    expChs:  {18'd0, 3'd7, 3'd0},
                    expData: {24'd0, 4'd8, 4'd1},
                    expLat: 8'd6, expBusy: 1'b1};
        vecs[3] = '{mask: 8'h00, base: 4'd2, expCount: 4'd0,
                    expChs:  24'd0,
                    expData: 32'd0,
                    expLat: 8'd0, expBusy: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstSel",     32'(sel),       32'd0);
        checkOutput("rstBusy",    32'(busy),      32'd0);
        checkOutput("rstValid",   32'(out_valid), 32'd0);
        checkOutput("rstCh",      32'(out_ch),    32'd0);
        checkOutput("rstData",    32'(out_data),  32'd0);
        checkOutput("rstDone",    32'(done),      32'd0);

        // Table of complete scans with out_ready held high.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].mask, vecs[v].base);
            waitScanDone(lat);
            checkOutput($sformatf("v%0d.capCount", v), 32'(capQ.size()), 32'(vecs[v].expCount));
            for (int k = 0; k < capQ.size() && k < int'(vecs[v].expCount); k++) begin
                eCh   = vecs[v].expChs[3*k +: 3];
                eData = vecs[v].expData[4*k +: 4];
                checkOutput($sformatf("v%0d.cap%0d", v, k), 32'(capQ[k]), 32'({eCh, eData}));
            end
            for (int k = 1; k < capCyc.size(); k++) begin
                checkOutput($sformatf("v%0d.spacing%0d", v, k),
                            32'(capCyc[k] - capCyc[k-1]), 32'(DWELL + 1));
            end
            checkOutput($sformatf("v%0d.doneLat", v), 32'(lat), 32'(vecs[v].expLat));
            checkOutput($sformatf("v%0d.donePulses", v), 32'(doneCount), 32'd1);
            checkOutput($sformatf("v%0d.doneWithBusy", v), 32'(doneWithBusy), 32'd0);
            checkOutput($sformatf("v%0d.busySeen", v), 32'(busySeen), 32'(vecs[v].expBusy));
            checkOutput($sformatf("v%0d.badSel", v), 32'(badSel), 32'd0);
        end

        // Back-pressure: out_ready low for 10 cycles on a single channel.
        out_ready = 1'b0;
        applyStimulus(8'h01, 4'd7);
        monActive = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        checkOutput("bpValid", 32'(out_valid), 32'd1);
        hb = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (!out_valid || out_ch != 3'd0 || out_data != 4'd7 || sel != 3'd0 || done) hb++;
        end
        checkOutput("bpHoldStable", 32'(hb), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bpDoneAfterReady", 32'(done), 32'd1);
        checkOutput("bpValidCleared",   32'(out_valid), 32'd0);
        checkOutput("bpBusyInDone",     32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("bpDoneOneCycle",   32'(done), 32'd0);
        checkOutput("bpSelKept",        32'(sel), 32'd0);

        // A second start during a running scan is ignored.
        applyStimulus(8'h03, 4'd2);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        mask = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        waitScanDone(lat);
        checkOutput("restartCapCount", 32'(capQ.size()), 32'd2);
        if (capQ.size() == 2) begin
            checkOutput("restartCap0", 32'(capQ[0]), 32'({3'd0, 4'd2}));
            checkOutput("restartCap1", 32'(capQ[1]), 32'({3'd1, 4'd3}));
        end
        checkOutput("restartLat", 32'(lat), 32'd6);
        hb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || out_valid) hb++;
        end
        checkOutput("restartNotQueued", 32'(hb), 32'd0);

        // Reset during HOLD on channel 3, then a clean single-channel scan.
        out_ready = 1'b0;
        applyStimulus(8'h08, 4'd4);
        monActive = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        checkOutput("holdCh3", 32'(out_ch), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstOutputs",
                    32'({sel, busy, out_valid, out_ch, out_data, done}), 32'd0);
        out_ready = 1'b1;
        applyStimulus(8'h08, 4'd9);
        waitScanDone(lat);
        checkOutput("postRstCapCount", 32'(capQ.size()), 32'd1);
        if (capQ.size() == 1) begin
            checkOutput("postRstCap", 32'(capQ[0]), 32'({3'd3, 4'd12}));
        end
        checkOutput("postRstLat", 32'(lat), 32'd3);

`ifdef SCAN_CHANGE_DETECT_EN
        // Change detection: a repeat scan only reports the changed channel.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(8'hFF, 4'd1);
        waitScanDone(lat);
        checkOutput("cdFirstCount", 32'(capQ.size()), 32'd8);
        checkOutput("cdFirstLat",   32'(lat), 32'd24);
        bumpCh4 = 1'b1;
        applyStimulus(8'hFF, 4'd1);
        waitScanDone(lat);
        checkOutput("cdSecondCount", 32'(capQ.size()), 32'd1);
        if (capQ.size() == 1) begin
            checkOutput("cdSecondCap", 32'(capQ[0]), 32'({3'd4, 4'd6}));
        end
        checkOutput("cdSecondLat", 32'(lat), 32'(8 * DWELL + 1));
        bumpCh4 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
